// File: rtl/pc_sequencer.sv
// pc_sequencer: control-flow sequencer for the 8-bit program counter.
// Turns decoded control-flow ops, ALU flags and interrupt requests into
// registered load controls for the counter, and owns the return-address
// stack, a single-level interrupt context and the HALT spin state.
module pc_sequencer #(
    parameter int         DEPTH      = 4,
    parameter logic [7:0] IRQ_VECTOR = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pcAddr,
    input  logic       ctlValid,
    input  logic [2:0] ctlOp,
    input  logic [7:0] ctlTarget,
    input  logic       zeroFlag,
    input  logic       carryFlag,
    input  logic       irq,
    input  logic       irqEnable,
    output logic       loadAddr,
    output logic [7:0] inAddr,
    output logic [3:0] stackDepth,
    output logic       inIsr,
    output logic       halted,
    output logic       stackErr
);

    localparam int         IW        = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JC   = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_RETI = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t     state, state_next;
    logic       load_q, load_next;
    logic [7:0] addr_q, addr_next;
    logic [3:0] depth_q, depth_next;
    logic       isr_q, isr_next;
    logic       err_q, err_next;
    logic [7:0] halt_addr, halt_addr_next;

    logic [7:0] stack [DEPTH];
    logic          push_en;
    logic [7:0]    push_data;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] pop_idx;
    logic [7:0]    pop_data;
    logic          stack_full;
    logic          stack_empty;
    logic          irq_take;

    assign push_idx    = depth_q[IW-1:0];
    assign pop_idx     = IW'(depth_q - 4'd1);
    assign pop_data    = stack[pop_idx];
    assign stack_full  = (depth_q >= DEPTH_MAX);
    assign stack_empty = (depth_q == 4'd0);

    // An interrupt is only accepted at an instruction boundary that consumes
    // nothing (idle, NOP or HALT) and only when there is room for the resume
    // address; otherwise it simply waits and is looked at again next cycle.
    assign irq_take = irq && irqEnable && !isr_q && !stack_full &&
                      ((state == ST_HALT) || !ctlValid || (ctlOp == OP_NOP));

    // State and registered control outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            load_q    <= 1'b0;
            addr_q    <= 8'h00;
            depth_q   <= 4'd0;
            isr_q     <= 1'b0;
            err_q     <= 1'b0;
            halt_addr <= 8'h00;
        end else begin
            state     <= state_next;
            load_q    <= load_next;
            addr_q    <= addr_next;
            depth_q   <= depth_next;
            isr_q     <= isr_next;
            err_q     <= err_next;
            halt_addr <= halt_addr_next;
        end
    end

    // Return-stack storage; contents need no reset because depth gates use.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            stack[push_idx] <= push_data;
        end
    end

    // Next-state logic: interrupt entry has priority, then HALT spin, then ops.
    always_comb begin
        state_next     = state;
        load_next      = 1'b0;
        addr_next      = addr_q;
        depth_next     = depth_q;
        isr_next       = isr_q;
        err_next       = err_q;
        halt_addr_next = halt_addr;
        push_en        = 1'b0;
        push_data      = 8'h00;

        if (irq_take) begin
            push_en    = 1'b1;
            push_data  = (state == ST_HALT) ? (halt_addr + 8'd1) : pcAddr;
            depth_next = depth_q + 4'd1;
            load_next  = 1'b1;
            addr_next  = IRQ_VECTOR;
            isr_next   = 1'b1;
            state_next = ST_RUN;
        end else if (state == ST_HALT) begin
            load_next = 1'b1;
            addr_next = halt_addr;
        end else if (ctlValid) begin
            case (ctlOp)
                OP_NOP: begin
                end
                OP_JMP: begin
                    load_next = 1'b1;
                    addr_next = ctlTarget;
                end
                OP_JZ: begin
                    if (zeroFlag) begin
                        load_next = 1'b1;
                        addr_next = ctlTarget;
                    end
                end
                OP_JC: begin
                    if (carryFlag) begin
                        load_next = 1'b1;
                        addr_next = ctlTarget;
                    end
                end
                OP_CALL: begin
                    if (stack_full) begin
                        err_next = 1'b1;
                    end else begin
                        push_en    = 1'b1;
                        push_data  = pcAddr + 8'd1;
                        depth_next = depth_q + 4'd1;
                        load_next  = 1'b1;
                        addr_next  = ctlTarget;
                    end
                end
                OP_RET, OP_RETI: begin
                    if (stack_empty) begin
                        err_next = 1'b1;
                    end else begin
                        depth_next = depth_q - 4'd1;
                        load_next  = 1'b1;
                        addr_next  = pop_data;
                    end
                    if (ctlOp == OP_RETI) begin
                        isr_next = 1'b0;
                    end
                end
                OP_HALT: begin
                    state_next     = ST_HALT;
                    halt_addr_next = pcAddr;
                    load_next      = 1'b1;
                    addr_next      = pcAddr;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs come straight from registers; halted reflects the FSM state.
    always_comb begin
        loadAddr   = load_q;
        inAddr     = addr_q;
        stackDepth = depth_q;
        inIsr      = isr_q;
        halted     = (state == ST_HALT);
        stackErr   = err_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer.
// Stimulus pushes the expected post-edge outputs; a monitor pops and compares.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst, ctlValid, zeroFlag, carryFlag, irq, irqEnable;
    logic [7:0] pcAddr, ctlTarget;
    logic [2:0] ctlOp;
    logic       loadAddr, inIsr, halted, stackErr;
    logic [7:0] inAddr;
    logic [3:0] stackDepth;

    typedef struct packed {
        logic       ld;
        logic [7:0] addr;
        logic [3:0] depth;
        logic       isr;
        logic       hlt;
        logic       err;
    } exp_t;

    exp_t expQ [$];
    int   testsRun  = 0;
    int   testsFail = 0;
    int   cycleNo   = 0;

    localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, JZ = 3'd2, JC = 3'd3;
    localparam logic [2:0] CALL = 3'd4, RET = 3'd5, RETI = 3'd6, HLT = 3'd7;

    pc_sequencer #(.DEPTH(4), .IRQ_VECTOR(8'hF0)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcAddr     (pcAddr),
        .ctlValid   (ctlValid),
        .ctlOp      (ctlOp),
        .ctlTarget  (ctlTarget),
        .zeroFlag   (zeroFlag),
        .carryFlag  (carryFlag),
        .irq        (irq),
        .irqEnable  (irqEnable),
        .loadAddr   (loadAddr),
        .inAddr     (inAddr),
        .stackDepth (stackDepth),
        .inIsr      (inIsr),
        .halted     (halted),
        .stackErr   (stackErr)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue its expectation.
    task automatic applyStimulus(input logic r, input logic v, input logic [2:0] op,
                                 input logic [7:0] tgt, input logic [7:0] pc,
                                 input logic z, input logic c, input logic i,
                                 input logic ie, input exp_t e);
        @(negedge clk);
        rst       = r;
        ctlValid  = v;
        ctlOp     = op;
        ctlTarget = tgt;
        pcAddr    = pc;
        zeroFlag  = z;
        carryFlag = c;
        irq       = i;
        irqEnable = ie;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        exp_t act;
        act = '{loadAddr, inAddr, stackDepth, inIsr, halted, stackErr};
        testsRun++;
        if (act !== e) begin
            testsFail++;
            $display("[TB] FAIL cycle%0d outputs: got ld=%b addr=%h depth=%0d isr=%b halt=%b err=%b, want ld=%b addr=%h depth=%0d isr=%b halt=%b err=%b",
                     cycleNo, act.ld, act.addr, act.depth, act.isr, act.hlt, act.err,
                     e.ld, e.addr, e.depth, e.isr, e.hlt, e.err);
        end
    endtask

    // Monitor: just after each rising edge, compare the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            cycleNo++;
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; ctlValid = 1'b0; ctlOp = NOP; ctlTarget = 8'h00; pcAddr = 8'h00;
        zeroFlag = 1'b0; carryFlag = 1'b0; irq = 1'b0; irqEnable = 1'b0;

        //            rst v  op    tgt    pc     z  c  irq ie   ld addr  dep isr hlt err
        applyStimulus(1, 0, NOP,  8'h00, 8'h00, 0, 0, 0, 0, '{0, 8'h00, 0, 0, 0, 0});
        applyStimulus(1, 0, NOP,  8'h00, 8'h00, 0, 0, 0, 0, '{0, 8'h00, 0, 0, 0, 0});
        applyStimulus(0, 1, JMP,  8'h3C, 8'h01, 0, 0, 0, 0, '{1, 8'h3C, 0, 0, 0, 0});
        applyStimulus(0, 1, NOP,  8'h00, 8'h3C, 0, 0, 0, 0, '{0, 8'h3C, 0, 0, 0, 0});
        applyStimulus(0, 1, JZ,   8'h20, 8'h3D, 0, 0, 0, 0, '{0, 8'h3C, 0, 0, 0, 0});
        applyStimulus(0, 1, JZ,   8'h20, 8'h3E, 1, 0, 0, 0, '{1, 8'h20, 0, 0, 0, 0});
        applyStimulus(0, 1, JC,   8'h44, 8'h20, 0, 1, 0, 0, '{1, 8'h44, 0, 0, 0, 0});
        // Nested calls up to full, then overflow
        applyStimulus(0, 1, CALL, 8'h80, 8'd10, 0, 0, 0, 0, '{1, 8'h80, 1, 0, 0, 0});
        applyStimulus(0, 1, CALL, 8'h81, 8'd20, 0, 0, 0, 0, '{1, 8'h81, 2, 0, 0, 0});
        applyStimulus(0, 1, CALL, 8'h82, 8'd30, 0, 0, 0, 0, '{1, 8'h82, 3, 0, 0, 0});
        applyStimulus(0, 1, CALL, 8'h83, 8'd40, 0, 0, 0, 0, '{1, 8'h83, 4, 0, 0, 0});
        applyStimulus(0, 1, CALL, 8'h84, 8'd50, 0, 0, 0, 0, '{0, 8'h83, 4, 0, 0, 1});
        // Unwind, then underflow
        applyStimulus(0, 1, RET,  8'h00, 8'h83, 0, 0, 0, 0, '{1, 8'd41, 3, 0, 0, 1});
        applyStimulus(0, 1, RET,  8'h00, 8'd41, 0, 0, 0, 0, '{1, 8'd31, 2, 0, 0, 1});
        applyStimulus(0, 1, RET,  8'h00, 8'd31, 0, 0, 0, 0, '{1, 8'd21, 1, 0, 0, 1});
        applyStimulus(0, 1, RET,  8'h00, 8'd21, 0, 0, 0, 0, '{1, 8'd11, 0, 0, 0, 1});
        applyStimulus(0, 1, RET,  8'h00, 8'd11, 0, 0, 0, 0, '{0, 8'd11, 0, 0, 0, 1});
        // Return address wraps from 8'hFF to 8'h00
        applyStimulus(0, 1, CALL, 8'h90, 8'hFF, 0, 0, 0, 0, '{1, 8'h90, 1, 0, 0, 1});
        applyStimulus(0, 1, RET,  8'h00, 8'h90, 0, 0, 0, 0, '{1, 8'h00, 0, 0, 0, 1});
        // Interrupt deferred by JMP, taken when idle, ignored while in ISR
        applyStimulus(0, 1, JMP,  8'h60, 8'h00, 0, 0, 1, 1, '{1, 8'h60, 0, 0, 0, 1});
        applyStimulus(0, 0, NOP,  8'h00, 8'h52, 0, 0, 1, 1, '{1, 8'hF0, 1, 1, 0, 1});
        applyStimulus(0, 0, NOP,  8'h00, 8'hF0, 0, 0, 1, 1, '{0, 8'hF0, 1, 1, 0, 1});
        applyStimulus(0, 1, RETI, 8'h00, 8'hF1, 0, 0, 0, 1, '{1, 8'h52, 0, 0, 0, 1});
        // HALT spin, ignored JMP, interrupt wake, return past the HALT
        applyStimulus(0, 1, HLT,  8'h00, 8'h07, 0, 0, 0, 1, '{1, 8'h07, 0, 0, 1, 1});
        applyStimulus(0, 1, JMP,  8'h33, 8'h07, 0, 0, 0, 1, '{1, 8'h07, 0, 0, 1, 1});
        applyStimulus(0, 0, NOP,  8'h00, 8'h07, 0, 0, 0, 1, '{1, 8'h07, 0, 0, 1, 1});
        applyStimulus(0, 0, NOP,  8'h00, 8'h07, 0, 0, 1, 1, '{1, 8'hF0, 1, 1, 0, 1});
        applyStimulus(0, 1, RETI, 8'h00, 8'hF0, 0, 0, 0, 1, '{1, 8'h08, 0, 0, 0, 1});
        // HALT again, then reset clears everything including sticky error
        applyStimulus(0, 1, HLT,  8'h00, 8'h07, 0, 0, 0, 1, '{1, 8'h07, 0, 0, 1, 1});
        applyStimulus(1, 0, NOP,  8'h00, 8'h07, 0, 0, 0, 1, '{0, 8'h00, 0, 0, 0, 0});
        // Interrupt with enable low is never taken
        applyStimulus(0, 0, NOP,  8'h00, 8'h10, 0, 0, 1, 0, '{0, 8'h00, 0, 0, 0, 0});
        applyStimulus(0, 0, NOP,  8'h00, 8'h10, 0, 0, 0, 0, '{0, 8'h00, 0, 0, 0, 0});

        repeat (3) @(posedge clk);
        #2;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFail++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control-flow sequencer for the 8-bit program counter. Each cycle it evaluates the decoded control-flow operation, the ALU flags and the interrupt request. It then produces the counter's `loadAddr`/`inAddr` controls. It owns a return-address stack for CALL/RET, a single-level interrupt entry/exit, and a HALT spin state. It sits between the instruction decoder and the program counter.

## Interface
- `DEPTH`, default 4: return-stack entries (2..8).
- `IRQ_VECTOR`, default 8'hF0: interrupt entry address.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pcAddr` in 8: current program-counter value, i.e. the address of the instruction being presented.
- `ctlValid` in 1: `ctlOp` and `ctlTarget` are valid this cycle.
- `ctlOp` in 3: operation code.
  - 000 NOP
  - 001 JMP
  - 010 JZ
  - 011 JC
  - 100 CALL
  - 101 RET
  - 110 RETI
  - 111 HALT
- `ctlTarget` in 8: jump/call destination.
- `zeroFlag`, `carryFlag` in 1 each: ALU flags, sampled with the op.
- `irq` in 1: level-sensitive interrupt request.
- `irqEnable` in 1: global interrupt enable.
- `loadAddr` out 1: registered; the counter loads `inAddr` instead of incrementing.
- `inAddr` out 8: registered load address.
- `stackDepth` out 4: number of valid return-stack entries.
- `inIsr` out 1: interrupt service in progress.
- `halted` out 1: HALT spin state active.
- `stackErr` out 1: sticky; set on overflow or underflow.

## Operation
- States: RUN, HALT. Reset puts the block in RUN.
- Reset values:
  - `loadAddr`=0, `inAddr`=8'h00, `stackDepth`=0, `inIsr`=0, `halted`=0, `stackErr`=0.
  - Stack contents are don't-care.
- The ops below apply in RUN with `ctlValid`=1 and no interrupt taken. Each edge registers `loadAddr`/`inAddr`. A cycle with no load drives `loadAddr`=0 and leaves `inAddr` holding its last value.
- NOP: no load.
- JMP: load `ctlTarget`.
- JZ: load `ctlTarget` if `zeroFlag`=1, else no load.
- JC: same as JZ, using `carryFlag`.
- CALL:
  - Not full: push `pcAddr`+1 (mod 256; 8'hFF wraps to 8'h00), depth+1, load `ctlTarget`.
  - Full (depth=`DEPTH`): no push, no load, `stackErr`←1.
- RET:
  - Not empty: pop, depth−1, load the popped address.
  - Empty: no load, `stackErr`←1.
- RETI: as RET, and additionally `inIsr`←0. `inIsr` clears even on underflow.
- HALT: `halted`←1, enter HALT, load `pcAddr`. The saved `haltAddr`=`pcAddr`.
- Interrupt take condition, all of the following:
  - `irq`=1, `irqEnable`=1, `inIsr`=0, depth<`DEPTH`;
  - and either `ctlValid`=0, or `ctlOp` is NOP, or the block is in HALT.
- Interrupt take action:
  - Push the resume address. In RUN this is `pcAddr`, since the instruction is not consumed. In HALT it is `haltAddr`+1.
  - depth+1, load `IRQ_VECTOR`, `inIsr`←1.
  - In HALT, also `halted`←0 and return to RUN.
- Interrupt deferral: `irq` during a non-NOP valid op, or with the stack full, is not taken that cycle. It is re-evaluated every following cycle. Deferral never sets `stackErr`.
- HALT state:
  - `loadAddr`=1, `inAddr`=`haltAddr` every cycle.
  - `ctlValid`/`ctlOp` are ignored.
  - Exit only by interrupt take or `rst`.
- Stack: LIFO, push and pop never in the same cycle. `stackErr` clears only on `rst`.
- `rst` mid-operation: the whole block returns to reset values on that edge, including HALT and ISR exit.

## Timing
- Inputs are sampled at rising edge N. The resulting `loadAddr`/`inAddr` are valid from edge N until edge N+1, one cycle of latency. Outputs are therefore stable before the counter's falling-edge capture.
- `stackDepth`, `inIsr`, `halted`, `stackErr` update at the same edge as the load they accompany.
- A load is asserted for exactly one cycle per op. In HALT it is continuous.
- Combinational inputs-to-outputs paths: none.

## Test plan
- Reset, then NOP and JMP:
  - Hold `rst` 2 cycles → all outputs 0.
  - JMP `ctlTarget`=8'h3C → next cycle `loadAddr`=1, `inAddr`=8'h3C; the following NOP gives `loadAddr`=0.
- Conditional branches:
  - JZ 8'h20 with `zeroFlag`=0 → no load.
  - JZ 8'h20 with `zeroFlag`=1 → load 8'h20.
  - JC 8'h44 with `carryFlag`=1 → load 8'h44.
- Nested calls, overflow and underflow (`DEPTH`=4):
  - CALLs at `pcAddr` 10,20,30,40 → depth 4.
  - Fifth CALL → no load, `stackErr`=1, depth stays 4.
  - Four RETs → loads 41,31,21,11 in that order.
  - Fifth RET → no load, depth 0.
- CALL wrap: CALL at `pcAddr`=8'hFF, then RET → RET loads 8'h00.
- Interrupt:
  - `irq`=1, `irqEnable`=1 during JMP → deferred.
  - Next cycle, `ctlValid`=0 with `pcAddr`=8'h52 → load 8'hF0, `inIsr`=1.
  - Second `irq` while `inIsr`=1 → ignored.
  - RETI → load 8'h52, `inIsr`=0.
- HALT then wake:
  - HALT at `pcAddr`=8'h07 → `halted`=1, `inAddr`=8'h07 with `loadAddr`=1 every cycle; a valid JMP during HALT is ignored.
  - `irq` → load 8'hF0, `halted`=0; RETI → load 8'h08.
  - Repeat the HALT, then assert `rst` → all outputs 0 the next cycle.
